wb_master_arbiter: RTL

- Round-robin Wishbone arbiter that shares one Wishbone slave bus between NUM_MASTERS masters.
- Master 0 is the hostbus gateway (wb_hb_wrapper). The other ports serve on-chip masters such as DMA or a debug UART.
- Sits between the masters' wb_* outputs and the shared slave/register decode. Grants a whole wb_cycle, not individual strobes.

---
 rtl/wb_arb_pkg.sv | 42 ++++
 rtl/wb_rr_pick.sv | 54 +++++
 rtl/wb_master_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared types, constants and the round-robin selection function
//             for the Wishbone master arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

    // Arbiter states: IDLE owns no grant, BUSY holds one registered grant.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Read data returned to a master whose strobe is forcibly terminated.
    localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

    // Returns the one-hot selection of the first requester found scanning
    // upward from last+1, wrapping modulo n. Zero when nobody requests.
    // Sized for the largest supported master count (8).
    function automatic logic [7:0] rr_next(input logic [7:0]  req,
                                           input logic [2:0]  last,
                                           input int unsigned n);
        logic [7:0] sel;
        logic [2:0] idx;
        sel = '0;
        // Walk from the farthest candidate down to the nearest so the
        // nearest requester is the one left in sel.
        for (int unsigned k = 8; k >= 1; k--) begin
            if (k <= n) begin
                idx = 3'((32'(last) + k) % n);
                if (req[idx]) begin
                    sel = 8'b1 << idx;
                end
            end
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : wb_rr_pick
//  Purpose  : Combinational round-robin picker with its last-grant pointer.
//             The pointer resets to NUM_MASTERS-1 so master 0 wins first.
//  Revision : 1.0  initial release
// ============================================================================
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   update,
    output logic [NUM_MASTERS-1:0] pick
);

    logic [7:0] w_req_ext;
    logic [7:0] w_pick_ext;
    logic [2:0] w_pick_idx;
    logic [2:0] r_last;

    // Widen the request vector to the function's fixed 8-bit form.
    always_comb begin
        w_req_ext                  = '0;
        w_req_ext[NUM_MASTERS-1:0] = req;
    end

    assign w_pick_ext = rr_next(w_req_ext, r_last, unsigned'(NUM_MASTERS));
    assign pick       = w_pick_ext[NUM_MASTERS-1:0];

    // One-hot to index conversion of the current pick.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_pick_ext[i]) begin
                w_pick_idx = 3'(i);
            end
        end
    end

    // Last-grant pointer advances only when a grant is actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 3'(NUM_MASTERS - 1);
        end else if (update && (|w_pick_ext)) begin
            r_last <= w_pick_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_master_arbiter
//  Purpose  : Round-robin arbiter sharing one Wishbone slave bus between
//             NUM_MASTERS masters. A grant covers a whole wb_cycle; at least
//             one idle cycle separates consecutive owners.
//             Optional build macro WB_ARB_TIMEOUT_EN adds a stall counter that
//             force-acks a strobe left unacknowledged for TIMEOUT_CYCLES
//             cycles and raises a sticky timeout_flag. DW must be a multiple
//             of 16.
//  Revision : 1.0  initial release
// ============================================================================
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 16,
    parameter int DW             = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_cycle,
    input  logic [NUM_MASTERS-1:0]    m_strobe,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [NUM_MASTERS*AW-1:0] m_addr,
    input  logic [NUM_MASTERS*DW-1:0] m_wrData,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [DW-1:0]             m_rdData,
    output logic                      s_cycle,
    output logic                      s_strobe,
    output logic                      s_write,
    output logic [AW-1:0]             s_addr,
    output logic [DW-1:0]             s_wrData,
    input  logic                      s_ack,
    input  logic [DW-1:0]             s_rdData,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      timeout_flag
);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [NUM_MASTERS-1:0] w_pick;
    logic                   w_pick_update;
    logic                   w_g_cycle;
    logic                   w_g_strobe;
    logic                   w_g_write;
    logic [AW-1:0]          w_g_addr;
    logic [DW-1:0]          w_g_wrdata;
    logic                   w_timeout;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .clk    (clk),
        .rst    (rst),
        .req    (m_cycle),
        .update (w_pick_update),
        .pick   (w_pick)
    );

    // State and grant registers; reset aborts any cycle in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Next-state logic: grant on any request in IDLE, release when the owner
    // drops its cycle. BUSY always returns through IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_pick_update = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|m_cycle) begin
                    w_state_nxt   = ST_BUSY;
                    w_grant_nxt   = w_pick;
                    w_pick_update = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!w_g_cycle) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Owner mux off the grant register; all-zero grant yields all-zero bus.
    always_comb begin
        w_g_cycle  = 1'b0;
        w_g_strobe = 1'b0;
        w_g_write  = 1'b0;
        w_g_addr   = '0;
        w_g_wrdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                w_g_cycle  = m_cycle[i];
                w_g_strobe = m_strobe[i];
                w_g_write  = m_write[i];
                w_g_addr   = m_addr[i*AW +: AW];
                w_g_wrdata = m_wrData[i*DW +: DW];
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_cnt_w-1:0] r_to_cnt;
    logic               r_to_flag;
    logic               w_stall;

    assign w_stall   = (r_state == ST_BUSY) && w_g_strobe && !s_ack;
    assign w_timeout = w_stall && (r_to_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    // Stall counter: counts unacknowledged strobe cycles, restarts after a
    // forced termination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_stall && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Sticky flag recording that at least one forced termination occurred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_flag <= 1'b0;
        end else if (w_timeout) begin
            r_to_flag <= 1'b1;
        end
    end

    assign timeout_flag = r_to_flag;
    assign m_rdData     = w_timeout ? {(DW/16){TIMEOUT_RDATA}} : s_rdData;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;

    assign w_timeout    = 1'b0;
    assign timeout_flag = 1'b0;
    assign m_rdData     = s_rdData;
`endif

    assign grant    = r_grant;
    assign s_cycle  = w_g_cycle;
    assign s_strobe = w_g_strobe & ~w_timeout;
    assign s_write  = w_g_write;
    assign s_addr   = w_g_addr;
    assign s_wrData = w_g_wrdata;

    // Ack is routed only to the owner and only while it strobes.
    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ack
            assign m_ack[i] = r_grant[i] & ((s_ack & m_strobe[i]) | w_timeout);
        end
    endgenerate

endmodule
`default_nettype wire
